// File: rtl/conv_layer_seq_if.sv
// Control, kernel-fetch, pixel-stream and output-write signals of conv_layer_seq.
interface conv_layer_seq_if #(
  parameter int DW = 8,
  parameter int PW = 20,
  parameter int AW = 10
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 k_req;
  logic [3:0]           k_oc;
  logic [3:0]           k_ic;
  logic                 k_valid;
  logic signed [DW-1:0] bias;
  logic                 conv_start;
  logic                 pix_valid;
  logic [AW-1:0]        pix_addr;
  logic signed [PW-1:0] pix_data;
  logic                 conv_done;
  logic                 out_we;
  logic [3:0]           out_c;
  logic [AW-1:0]        out_addr;
  logic signed [DW-1:0] out_data;

  modport master (
    input  start, k_valid, bias, pix_valid, pix_addr, pix_data, conv_done,
    output busy, done, k_req, k_oc, k_ic, conv_start, out_we, out_c, out_addr, out_data
  );

  modport slave (
    output start, k_valid, bias, pix_valid, pix_addr, pix_data, conv_done,
    input  busy, done, k_req, k_oc, k_ic, conv_start, out_we, out_c, out_addr, out_data
  );
endinterface

// File: rtl/conv_layer_seq.sv
// Sequences OC x IC conv passes, accumulating per-pixel partial sums; CONV_RELU_EN clamps negatives.
// Output write lands 1 cycle after pix_valid; LOAD stalls until k_valid, CONV until conv_done.
module conv_layer_seq #(
  parameter int OC    = 8,
  parameter int IC    = 4,
  parameter int H     = 28,
  parameter int W     = 28,
  parameter int DW    = 8,
  parameter int PW    = 20,
  parameter int SHIFT = 0
) (
  input  logic clk,
  input  logic rst,
  conv_layer_seq_if.master bus
);
  localparam int N  = H * W;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  localparam logic [3:0] OC_LAST = 4'(OC - 1);
  localparam logic [3:0] IC_LAST = 4'(IC - 1);
  localparam logic signed [PW-1:0] SAT_HI = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_LO = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, CONV, NEXT, FINISH} state_t;

  state_t               state;
  logic [3:0]           oc;
  logic [3:0]           ic;
  logic signed [DW-1:0] bias_r;
  logic signed [PW-1:0] psum [N];

  logic                 first_pass;
  logic                 last_pass;
  logic signed [PW-1:0] acc_base;
  logic signed [PW-1:0] acc_sum;

  assign first_pass = (ic == 4'd0);
  assign last_pass  = (ic == IC_LAST);
  // With IC=1 the first pass is also the last, so bias goes straight to the output path.
  assign acc_base   = first_pass ? PW'(bias_r) : psum[bus.pix_addr];
  assign acc_sum    = acc_base + bus.pix_data;

  assign bus.k_oc = oc;
  assign bus.k_ic = ic;

  function automatic logic signed [DW-1:0] scale_sat(input logic signed [PW-1:0] s);
    logic signed [PW-1:0] sh;
    sh = s >>> SHIFT;
`ifdef CONV_RELU_EN
    if (sh[PW-1]) sh = '0;
`endif
    if (sh > SAT_HI)      return SAT_HI[DW-1:0];
    else if (sh < SAT_LO) return SAT_LO[DW-1:0];
    return sh[DW-1:0];
  endfunction

  // Partial sums carry no reset: every layer rewrites them in its ic==0 pass.
  always_ff @(posedge clk) begin
    if (state == CONV && bus.pix_valid && !last_pass)
      psum[bus.pix_addr] <= acc_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      oc             <= 4'd0;
      ic             <= 4'd0;
      bias_r         <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.k_req      <= 1'b0;
      bus.conv_start <= 1'b0;
      bus.out_we     <= 1'b0;
      bus.out_c      <= 4'd0;
      bus.out_addr   <= '0;
      bus.out_data   <= '0;
    end else begin
      bus.done       <= 1'b0;
      bus.conv_start <= 1'b0;
      bus.out_we     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= LOAD;
            bus.busy  <= 1'b1;
            bus.k_req <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.k_valid) begin
            bias_r         <= bus.bias;
            bus.k_req      <= 1'b0;
            bus.conv_start <= 1'b1;
            state          <= CONV;
          end
        end
        CONV: begin
          if (bus.pix_valid && last_pass) begin
            bus.out_we   <= 1'b1;
            bus.out_c    <= oc;
            bus.out_addr <= bus.pix_addr;
            bus.out_data <= scale_sat(acc_sum);
          end
          if (bus.conv_done)
            state <= NEXT;
        end
        NEXT: begin
          if (last_pass) begin
            ic <= 4'd0;
            if (oc == OC_LAST) begin
              oc    <= 4'd0;
              state <= FINISH;
            end else begin
              oc        <= oc + 4'd1;
              state     <= LOAD;
              bus.k_req <= 1'b1;
            end
          end else begin
            ic        <= ic + 4'd1;
            state     <= LOAD;
            bus.k_req <= 1'b1;
          end
        end
        FINISH: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
